// File: rtl/hamming_encoder_tx.sv
// hamming_encoder_tx
// Transmit-side encoder for the (21,18) single-parity-replica code. It
// accepts 18-bit words over a valid/ready handshake and builds the codeword
// {d[2:0], d[17:0]}. The codeword is held on a parallel output and is also
// shifted out one bit per clock, framed by sframe.
//
// Serial order is set by MSB_FIRST:
//   0 : cx[0]  is sent first, cx[20] last
//   1 : cx[20] is sent first, cx[0]  last
//
// Back-to-back words are accepted on the last bit of a frame, so that
// sframe stays high with no gap. d_ready depends only on state, cnt and
// rst, never on d_valid. This lets the source drive d_valid from d_ready
// without forming a combinational loop.

module hamming_encoder_tx #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] d,
    input  logic        d_valid,
    output logic        d_ready,
    output logic [20:0] cx,
    output logic        cx_valid,
    output logic        sout,
    output logic        sframe,
    output logic        busy
);

    // Index of the final bit of a frame. d_ready opens on this count.
    localparam logic [4:0] LAST_CNT = 5'd20;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Codeword layout: check bits 20:18 replicate data bits 2:0. The
    // decoder's syndrome s[i] = cx[i] ^ cx[18+i] is therefore zero for
    // every word this block emits.
    function automatic logic [20:0] encode(input logic [17:0] data);
        return {data[2:0], data};
    endfunction

    // Advance the shift register by one bit toward whichever end drives sout.
    function automatic logic [20:0] shift_once(input logic [20:0] sr);
        if (MSB_FIRST) begin
            return {sr[19:0], 1'b0};
        end
        return {1'b0, sr[20:1]};
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [20:0] cx_q,    cx_d;
    logic [20:0] sr_q,    sr_d;
    logic        cx_valid_q, cx_valid_d;

    logic        xfer;
    logic        out_bit;

    // Handshake: the block is ready when idle, or on the last bit of a frame.
    assign d_ready = !rst && ((state_q == IDLE) ||
                              ((state_q == SHIFT) && (cnt_q == LAST_CNT)));
    assign xfer    = d_valid && d_ready;

    // The bit on sout sits at the output end of the shift register.
    assign out_bit = MSB_FIRST ? sr_q[20] : sr_q[0];

    // Next-state, counter and datapath update for the serializer FSM.
    always_comb begin
        // NOTE: every signal gets its default first. Then no path through
        // the case statement leaves a signal unassigned, and no latch can
        // be inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        cx_d       = cx_q;
        sr_d       = sr_q;
        cx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d    = SHIFT;
                    cnt_d      = 5'd0;
                    cx_d       = encode(d);
                    sr_d       = encode(d);
                    cx_valid_d = 1'b1;
                end
            end

            SHIFT: begin
                if (cnt_q != LAST_CNT) begin
                    cnt_d = cnt_q + 5'd1;
                    sr_d  = shift_once(sr_q);
                end else if (xfer) begin
                    // Back-to-back: the next frame starts on the very next
                    // cycle, so sframe has no gap.
                    cnt_d      = 5'd0;
                    cx_d       = encode(d);
                    sr_d       = encode(d);
                    cx_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // State registers. All of them clear asynchronously, so a reset
    // mid-frame discards the partial frame at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop
        // then samples its _d value from before the edge, whatever order
        // the statements appear in.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            // NOTE: the 21-bit codeword and shift registers are plain flop
            // banks, not a RAM. Clearing them costs nothing and keeps cx
            // and sout defined straight out of reset.
            cx_q       <= '0;
            sr_q       <= '0;
            cx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cx_q       <= cx_d;
            sr_q       <= sr_d;
            cx_valid_q <= cx_valid_d;
        end
    end

    // Outputs are decoded from the registered state, so they drop as soon
    // as rst clears the state.
    assign cx       = cx_q;
    assign cx_valid = cx_valid_q;
    assign sframe   = (state_q == SHIFT);
    assign busy     = (state_q == SHIFT);
    assign sout     = (state_q == SHIFT) && out_bit;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Directed testbench for hamming_encoder_tx. Two instances share the same
// clock, reset and input stream. One sends LSB first and the other MSB
// first, so each vector checks both serial orders.

module tb_hamming_encoder_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] d = '0;
    logic        d_valid = 1'b0;

    logic        d_ready0, cx_valid0, sout0, sframe0, busy0;
    logic [20:0] cx0;
    logic        d_ready1, cx_valid1, sout1, sframe1, busy1;
    logic [20:0] cx1;

    int checks = 0;
    int errors = 0;

    hamming_encoder_tx #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready0),
        .cx(cx0), .cx_valid(cx_valid0), .sout(sout0), .sframe(sframe0),
        .busy(busy0)
    );

    hamming_encoder_tx #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready1),
        .cx(cx1), .cx_valid(cx_valid1), .sout(sout1), .sframe(sframe1),
        .busy(busy1)
    );

    always #5 clk = ~clk;

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        #1;
        obs = {d_ready0, cx_valid0, sout0, sframe0, busy0,
               d_ready1, cx_valid1, sout1, sframe1, busy1, 1'b0};
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000000", obs);
        end
        checks++;
        if (cx0 !== 21'd0 || cx1 !== 21'd0) begin
            errors++;
            $display("FAIL reset_cx: got %h/%h want 000000", cx0, cx1);
        end
        // Release the reset away from any clock edge.
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        checks++;
        if ({d_ready0, d_ready1, busy0, sframe0} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: got rdy/busy/frame %b want 1100",
                     {d_ready0, d_ready1, busy0, sframe0});
        end
    endtask

    task automatic test_single_lsb();
        logic [20:0] cx_exp;
        logic [4:0]  obs, exp;
        cx_exp = 21'h0AAAAA;
        d = 18'h2AAAA;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        d = 18'h15555;  // no transfer follows, so outputs must ignore this
        for (int k = 0; k < 21; k++) begin
            obs = {sframe0, sout0, sout1, cx_valid0, d_ready0};
            exp = {1'b1, cx_exp[k], cx_exp[20-k], (k == 0), (k == 20)};
            checks++;
            if (obs !== exp || cx0 !== cx_exp) begin
                errors++;
                $display("FAIL single_lsb k=%0d: got %b cx=%h want %b cx=%h",
                         k, obs, cx0, exp, cx_exp);
            end
            tick();
        end
        checks++;
        if ({sframe0, busy0, sout0, cx_valid0, d_ready0} !== 5'b00001 ||
            cx0 !== cx_exp) begin
            errors++;
            $display("FAIL single_lsb_idle: got %b cx=%h want 00001 cx=%h",
                     {sframe0, busy0, sout0, cx_valid0, d_ready0}, cx0, cx_exp);
        end
    endtask

    task automatic test_msb_first();
        logic [20:0] cx_exp;
        logic [2:0]  syn;
        logic [2:0]  obs, exp;
        cx_exp = 21'h1C0007;
        d = 18'h00007;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        checks++;
        if (cx1 !== cx_exp || cx_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL msb_cx: got %h v=%b want %h v=1", cx1, cx_valid1, cx_exp);
        end
        // Reference decoder: data = cx[17:0]; syndrome s[i] = cx[i] ^ cx[18+i].
        syn = cx1[2:0] ^ cx1[20:18];
        checks++;
        if (cx1[17:0] !== 18'h00007 || syn !== 3'b000) begin
            errors++;
            $display("FAIL msb_decode: got d=%h s=%b want d=00007 s=000",
                     cx1[17:0], syn);
        end
        for (int k = 0; k < 21; k++) begin
            obs = {sframe1, sout1, sout0};
            exp = {1'b1, cx_exp[20-k], cx_exp[k]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL msb_serial k=%0d: got %b want %b", k, obs, exp);
            end
            tick();
        end
        checks++;
        if ({sframe1, busy1, d_ready1} !== 3'b001) begin
            errors++;
            $display("FAIL msb_idle: got %b want 001", {sframe1, busy1, d_ready1});
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  obs, exp;
        logic [20:0] cx_exp;
        d = 18'h3FFFF;
        d_valid = 1'b1;
        tick();
        d = 18'h00000;  // d_valid stays high: the second word waits for cnt==20
        for (int i = 0; i < 42; i++) begin
            cx_exp = (i < 21) ? 21'h1FFFFF : 21'h000000;
            obs = {sframe0, sframe1, sout0, sout1, cx_valid0, d_ready0};
            exp = {1'b1, 1'b1, (i < 21), (i < 21), (i == 0 || i == 21),
                   (i == 20 || i == 41)};
            checks++;
            if (obs !== exp || cx0 !== cx_exp) begin
                errors++;
                $display("FAIL b2b i=%0d: got %b cx=%h want %b cx=%h",
                         i, obs, cx0, exp, cx_exp);
            end
            if (i == 21) d_valid = 1'b0;
            tick();
        end
        checks++;
        if ({sframe0, sframe1, cx_valid0} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_end: got %b want 000", {sframe0, sframe1, cx_valid0});
        end
    endtask

    task automatic test_backpressure();
        logic [20:0] cx_exp;
        logic [3:0]  obs, exp;
        d = 18'h3FFFF;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        repeat (5) tick();
        d = 18'h12345;
        d_valid = 1'b1;
        for (int c = 5; c <= 20; c++) begin
            obs = {sframe0, cx_valid0, d_ready0, d_ready1};
            exp = {1'b1, 1'b0, (c == 20), (c == 20)};
            checks++;
            if (obs !== exp || cx0 !== 21'h1FFFFF) begin
                errors++;
                $display("FAIL bp_hold cnt=%0d: got %b cx=%h want %b cx=1fffff",
                         c, obs, cx0, exp);
            end
            tick();
        end
        d_valid = 1'b0;
        // Check bits equal d[2:0] = 101, giving 0x140000 | 0x12345.
        cx_exp = 21'h152345;
        checks++;
        if (cx0 !== cx_exp || cx1 !== cx_exp || cx_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_load: got %h/%h v=%b want %h v=1",
                     cx0, cx1, cx_valid0, cx_exp);
        end
        for (int k = 0; k < 21; k++) begin
            obs = {sframe0, sout0, sout1, cx_valid0};
            exp = {1'b1, cx_exp[k], cx_exp[20-k], (k == 0)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bp_serial k=%0d: got %b want %b", k, obs, exp);
            end
            tick();
        end
        checks++;
        if ({sframe0, cx_valid0} !== 2'b00) begin
            errors++;
            $display("FAIL bp_idle: got %b want 00", {sframe0, cx_valid0});
        end
    endtask

    task automatic test_reset_midframe();
        logic [20:0] cx_exp;
        logic [2:0]  obs, exp;
        d = 18'h3FFFF;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        repeat (10) tick();  // cnt = 10
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sframe0, sout0, busy0, d_ready0, sframe1, sout1, cx_valid0} !== 7'd0 ||
            cx0 !== 21'd0) begin
            errors++;
            $display("FAIL midrst_async: got %b cx=%h want 0000000 cx=000000",
                     {sframe0, sout0, busy0, d_ready0, sframe1, sout1, cx_valid0}, cx0);
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if ({d_ready0, sframe0} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_release: got %b want 10", {d_ready0, sframe0});
        end
        cx_exp = 21'h040001;
        d = 18'h00001;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        checks++;
        if (cx0 !== cx_exp || cx1 !== cx_exp) begin
            errors++;
            $display("FAIL midrst_cx: got %h/%h want %h", cx0, cx1, cx_exp);
        end
        for (int k = 0; k < 21; k++) begin
            obs = {sframe0, sout0, sout1};
            exp = {1'b1, cx_exp[k], cx_exp[20-k]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst_serial k=%0d: got %b want %b", k, obs, exp);
            end
            tick();
        end
        checks++;
        if ({sframe0, busy0, d_ready0} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_idle: got %b want 001", {sframe0, busy0, d_ready0});
        end
    endtask

    initial begin
        test_reset();
        test_single_lsb();
        test_msb_first();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
